// File: rtl/regbank_pkg.sv
// Shared register-bank definitions: clear-FSM state encoding and the default
// datapath geometry that other blocks import.
package regbank_pkg;

    localparam int RB_WIDTH = 32;
    localparam int RB_DEPTH = 4;

    typedef enum logic {
        RB_IDLE  = 1'b0,
        RB_CLEAR = 1'b1
    } rb_state_e;

endpackage

// File: rtl/regbank_rd_port.sv
// One registered read port: range check, read mux, write/clear bypass and the
// output register. Returns the contents the addressed register holds after the edge.
module regbank_rd_port
    import regbank_pkg::*;
#(
    parameter int WIDTH    = RB_WIDTH,
    parameter int DEPTH    = RB_DEPTH,
    parameter bit ZERO_REG = 1'b0,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] regs [DEPTH],
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_A = (AW + 1)'(DEPTH);

    logic             in_range;
    logic [WIDTH-1:0] rd_next;

    // Clear and write never coincide: writes are only accepted while idle.
    always_comb begin
        in_range = {1'b0, addr} < DEPTH_A;
        rd_next  = '0;
        if (!in_range || (ZERO_REG && addr == '0)) begin
            rd_next = '0;
        end else if (clr_en && clr_addr == addr) begin
            rd_next = '0;
        end else if (wr_en && wr_addr == addr) begin
            rd_next = wr_data;
        end else begin
            rd_next = regs[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: rtl/regbank_param.sv
// DEPTH x WIDTH register file with two registered write-first read ports, one
// write port, optional hardwired-zero register 0 and a sequential bulk-clear engine.
module regbank_param
    import regbank_pkg::*;
#(
    parameter int  WIDTH    = RB_WIDTH,
    parameter int  DEPTH    = RB_DEPTH,
    parameter bit  ZERO_REG = 1'b0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    sr1,
    input  logic [AW-1:0]    sr2,
    input  logic [AW-1:0]    dr,
    input  logic             write,
    input  logic [WIDTH-1:0] wrData,
    input  logic             clr,
    output logic [WIDTH-1:0] rdData1,
    output logic [WIDTH-1:0] rdData2,
    output logic             busy,
    output logic             clr_done,
    output logic             wr_err,
    output logic             fsm_state
);

    localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    rb_state_e        state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             clr_done_d;
    logic [WIDTH-1:0] regs [DEPTH];

    logic wr_in_range;
    logic clearing;
    logic wr_accept;
    logic wr_drop;

    // clr is a request sampled only in IDLE; busy is the not-ready indication
    // for both clr and write, and clr_done is the single-cycle completion strobe.
    assign wr_in_range = {1'b0, dr} < DEPTH_A;
    assign clearing    = (state_q == RB_CLEAR);
    assign wr_accept   = write && !clearing && wr_in_range && !(ZERO_REG && dr == '0);
    assign wr_drop     = write && (clearing || !wr_in_range);
    assign busy        = clearing;
    assign fsm_state   = state_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            RB_IDLE: begin
                if (clr) begin
                    state_d = RB_CLEAR;
                    cnt_d   = '0;
                end
            end
            RB_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = RB_IDLE;
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = RB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RB_IDLE;
            cnt_q    <= '0;
            clr_done <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clr_done <= clr_done_d;
            wr_err   <= wr_drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clearing) begin
            regs[cnt_q] <= '0;
        end else if (wr_accept) begin
            regs[dr] <= wrData;
        end
    end

    regbank_rd_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG),
        .AW      (AW)
    ) u_rd1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (sr1),
        .regs    (regs),
        .wr_en   (wr_accept),
        .wr_addr (dr),
        .wr_data (wrData),
        .clr_en  (clearing),
        .clr_addr(cnt_q),
        .rd_data (rdData1)
    );

    regbank_rd_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG),
        .AW      (AW)
    ) u_rd2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (sr2),
        .regs    (regs),
        .wr_en   (wr_accept),
        .wr_addr (dr),
        .wr_data (wrData),
        .clr_en  (clearing),
        .clr_addr(cnt_q),
        .rd_data (rdData2)
    );

endmodule

// File: tb/tb_regbank_param.sv
// Bench for regbank_param: three configurations (4 regs, 4 regs with zero reg,
// 6 regs) share one stimulus stream and are checked against a per-cycle model.
module tb_regbank_param;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [2:0]  sr1     = '0;
    logic [2:0]  sr2     = '0;
    logic [2:0]  dr      = '0;
    logic        write   = 1'b0;
    logic        clr     = 1'b0;
    logic [31:0] wr_data = '0;

    logic [31:0] o_rd1  [3];
    logic [31:0] o_rd2  [3];
    logic        o_busy [3];
    logic        o_done [3];
    logic        o_err  [3];
    logic        o_st   [3];

    int checks    = 0;
    int errors    = 0;
    int busy_seen = 0;
    int done_seen = 0;

    // One entry per edge: three 67-bit slices {rd1, rd2, busy, done, err}.
    logic [200:0] exp_q [$];

    always #5 clk = ~clk;

    regbank_param #(.WIDTH(32), .DEPTH(4), .ZERO_REG(1'b0)) u_d4 (
        .clk(clk), .rst_n(rst_n), .sr1(sr1[1:0]), .sr2(sr2[1:0]), .dr(dr[1:0]),
        .write(write), .wrData(wr_data), .clr(clr),
        .rdData1(o_rd1[0]), .rdData2(o_rd2[0]), .busy(o_busy[0]),
        .clr_done(o_done[0]), .wr_err(o_err[0]), .fsm_state(o_st[0])
    );

    regbank_param #(.WIDTH(32), .DEPTH(4), .ZERO_REG(1'b1)) u_z4 (
        .clk(clk), .rst_n(rst_n), .sr1(sr1[1:0]), .sr2(sr2[1:0]), .dr(dr[1:0]),
        .write(write), .wrData(wr_data), .clr(clr),
        .rdData1(o_rd1[1]), .rdData2(o_rd2[1]), .busy(o_busy[1]),
        .clr_done(o_done[1]), .wr_err(o_err[1]), .fsm_state(o_st[1])
    );

    regbank_param #(.WIDTH(32), .DEPTH(6), .ZERO_REG(1'b0)) u_d6 (
        .clk(clk), .rst_n(rst_n), .sr1(sr1), .sr2(sr2), .dr(dr),
        .write(write), .wrData(wr_data), .clr(clr),
        .rdData1(o_rd1[2]), .rdData2(o_rd2[2]), .busy(o_busy[2]),
        .clr_done(o_done[2]), .wr_err(o_err[2]), .fsm_state(o_st[2])
    );

    task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h", name, c, got, exp);
        end
    endtask

    // Reference model: memory contents as plain arrays; reads see the post-edge contents.
    int          m_depth [3] = '{4, 4, 6};
    bit          m_zero  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] m_regs  [3][8];
    bit          m_busy  [3];
    int          m_idx   [3];

    always @(posedge clk) begin
        logic [200:0] e;
        logic [31:0]  r1, r2;
        int           a1, a2, d, mask;
        bit           err, done;
        e = '0;
        for (int c = 0; c < 3; c++) begin
            mask = (m_depth[c] > 4) ? 7 : 3;
            a1   = int'(sr1) & mask;
            a2   = int'(sr2) & mask;
            d    = int'(dr) & mask;
            err  = 1'b0;
            done = 1'b0;
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) m_regs[c][i] = '0;
                m_busy[c] = 1'b0;
                m_idx[c]  = 0;
            end else if (m_busy[c]) begin
                m_regs[c][m_idx[c]] = '0;
                if (write) err = 1'b1;
                if (m_idx[c] == m_depth[c] - 1) begin
                    m_busy[c] = 1'b0;
                    done      = 1'b1;
                end else begin
                    m_idx[c] = m_idx[c] + 1;
                end
            end else begin
                if (write) begin
                    if (d >= m_depth[c]) err = 1'b1;
                    else if (!(m_zero[c] && d == 0)) m_regs[c][d] = wr_data;
                end
                if (clr) begin
                    m_busy[c] = 1'b1;
                    m_idx[c]  = 0;
                end
            end
            r1 = (!rst_n || a1 >= m_depth[c] || (m_zero[c] && a1 == 0)) ? 32'h0 : m_regs[c][a1];
            r2 = (!rst_n || a2 >= m_depth[c] || (m_zero[c] && a2 == 0)) ? 32'h0 : m_regs[c][a2];
            e[c*67 +: 67] = {r1, r2, m_busy[c], done, err};
        end
        exp_q.push_back(e);
    end

    // Monitor: outputs are presented every cycle; compare away from the active edge.
    always @(negedge clk) begin
        logic [200:0] e;
        logic [66:0]  s;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int c = 0; c < 3; c++) begin
                s = e[c*67 +: 67];
                chk("rd_data1", c, o_rd1[c], s[66:35]);
                chk("rd_data2", c, o_rd2[c], s[34:3]);
                chk("busy", c, 32'(o_busy[c]), 32'(s[2]));
                chk("clr_done", c, 32'(o_done[c]), 32'(s[1]));
                chk("wr_err", c, 32'(o_err[c]), 32'(s[0]));
                chk("fsm_state", c, 32'(o_st[c]), 32'(s[2]));
            end
            if (o_busy[0]) busy_seen++;
            if (o_done[0]) done_seen++;
        end
    end

    task automatic drive(input logic w, input logic [2:0] d, input logic [31:0] data,
                         input logic c, input logic [2:0] a1, input logic [2:0] a2);
        @(negedge clk);
        write   = w;
        dr      = d;
        wr_data = data;
        clr     = c;
        sr1     = a1;
        sr2     = a2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic read_sweep();
        for (int a = 0; a < 8; a += 2) drive(1'b0, 3'd0, 32'h0, 1'b0, 3'(a), 3'(a + 1));
    endtask

    // Asserts reset between edges and checks the outputs clear before the next edge.
    task automatic reset_mid_cycle();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("async_rd_data1", c, o_rd1[c], 32'h0);
            chk("async_rd_data2", c, o_rd2[c], 32'h0);
            chk("async_busy", c, 32'(o_busy[c]), 32'h0);
            chk("async_clr_done", c, 32'(o_done[c]), 32'h0);
            chk("async_wr_err", c, 32'(o_err[c]), 32'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        read_sweep();

        // Populate, read back, then reset mid-cycle with live non-zero outputs.
        drive(1'b1, 3'd1, 32'hA1A1_0001, 1'b0, 3'd0, 3'd0);
        drive(1'b1, 3'd2, 32'hB2B2_0002, 1'b0, 3'd1, 3'd0);
        drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd1, 3'd2);
        reset_mid_cycle();
        read_sweep();

        // Write-first bypass, then the other port on the following edge.
        drive(1'b1, 3'd2, 32'hDEAD_BEEF, 1'b0, 3'd2, 3'd0);
        drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd2);

        // Register 0: hardwired zero in one instance, ordinary in the others.
        drive(1'b1, 3'd0, 32'h0000_1234, 1'b0, 3'd1, 3'd1);
        drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd0);

        // Bulk clear with a write attempted while busy.
        drive(1'b1, 3'd0, 32'h11, 1'b0, 3'd0, 3'd0);
        drive(1'b1, 3'd1, 32'h22, 1'b0, 3'd0, 3'd1);
        drive(1'b1, 3'd2, 32'h33, 1'b0, 3'd2, 3'd1);
        drive(1'b1, 3'd3, 32'h44, 1'b0, 3'd3, 3'd2);
        busy_seen = 0;
        done_seen = 0;
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 3'd0);
        drive(1'b1, 3'd1, 32'hFFFF_FFFF, 1'b1, 3'd1, 3'd3);
        idle(7);
        chk("busy_cycles", 0, 32'(busy_seen), 32'd4);
        chk("clr_done_pulses", 0, 32'(done_seen), 32'd1);
        read_sweep();

        // Reset on the second busy cycle aborts the clear with no completion pulse.
        drive(1'b1, 3'd3, 32'h5555_AAAA, 1'b0, 3'd0, 3'd0);
        done_seen = 0;
        drive(1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 3'd0);
        drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd3, 3'd3);
        reset_mid_cycle();
        idle(8);
        chk("clr_done_after_abort", 0, 32'(done_seen), 32'd0);
        read_sweep();

        // Out-of-range write and read on the 6-deep instance.
        for (int i = 0; i < 6; i++) drive(1'b1, 3'(i), 32'h100 + 32'(i), 1'b0, 3'd0, 3'd0);
        drive(1'b1, 3'd7, 32'hA5A5_A5A5, 1'b0, 3'd7, 3'd6);
        drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd7, 3'd5);
        read_sweep();

        // Randomised traffic with occasional clear requests.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        idle(8);
        read_sweep();
        idle(2);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
